// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, grant owner and
// latency counter width.
package dmem_arb_pkg;

  localparam int LAT_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU port, DMA port and memory side.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_ack_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_stall_o;

  logic              dma_req_i;
  logic              dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [DATA_W-1:0] dma_wdata_i;
  logic              dma_ack_o;
  logic [DATA_W-1:0] dma_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_ack_o, cpu_rdata_o, cpu_stall_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output dma_ack_o, dma_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_ack_o, cpu_rdata_o, cpu_stall_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  dma_ack_o, dma_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker. On a tie it grants the requester that
// did not win last time, or always the CPU when cpu_prio is set.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_dma,
  input  gnt_e last_grant,
  input  logic cpu_prio,
  output gnt_e grant,
  output logic valid
);

  always_comb begin
    valid = req_cpu | req_dma;
    grant = GNT_CPU;
    if (req_cpu && req_dma) begin
      grant = (cpu_prio || last_grant == GNT_DMA) ? GNT_CPU : GNT_DMA;
    end else if (req_dma) begin
      grant = GNT_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU and DMA accesses onto one fixed-latency memory.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority; default is round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam logic CPU_PRIO = 1'b1;
`else
  localparam logic CPU_PRIO = 1'b0;
`endif

  logic [1:0]        state;
  gnt_e              gnt;
  gnt_e              last_grant;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dma_rdata;
  gnt_e              pick_gnt;
  logic              pick_vld;

  rr_pick2 u_pick (
    .req_cpu    (bus.cpu_req_i),
    .req_dma    (bus.dma_req_i),
    .last_grant (last_grant),
    .cpu_prio   (CPU_PRIO),
    .grant      (pick_gnt),
    .valid      (pick_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt        <= GNT_CPU;
      last_grant <= GNT_DMA;
      lat_cnt    <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt        <= pick_gnt;
            last_grant <= pick_gnt;
            lat_we     <= (pick_gnt == GNT_DMA) ? bus.dma_we_i    : bus.cpu_we_i;
            lat_addr   <= (pick_gnt == GNT_DMA) ? bus.dma_addr_i  : bus.cpu_addr_i;
            lat_wdata  <= (pick_gnt == GNT_DMA) ? bus.dma_wdata_i : bus.cpu_wdata_i;
            lat_cnt    <= LAT_W'(MEM_LAT - 1);
            state      <= BUSY;
          end
        end
        // memory read data is only valid on the final busy cycle
        BUSY: begin
          if (lat_cnt == '0) begin
            if (!lat_we) begin
              if (gnt == GNT_DMA) dma_rdata <= bus.mem_rdata_i;
              else                cpu_rdata <= bus.mem_rdata_i;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en_o    = (state == BUSY);
  assign bus.mem_we_o    = (state == BUSY) && lat_we;
  assign bus.mem_addr_o  = lat_addr;
  assign bus.mem_wdata_o = lat_wdata;

  assign bus.cpu_ack_o   = (state == DONE) && (gnt == GNT_CPU);
  assign bus.dma_ack_o   = (state == DONE) && (gnt == GNT_DMA);
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.dma_rdata_o = dma_rdata;

  // the pipeline advances on the edge that samples the ack
  assign bus.cpu_stall_o = bus.cpu_req_i & ~bus.cpu_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) share stimulus;
// sel chooses which one is observed and checked against the bench's models.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic        sel = 1'b0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  assign bus0.cpu_req_i = cpu_req;  assign bus1.cpu_req_i = cpu_req;
  assign bus0.cpu_we_i = cpu_we;    assign bus1.cpu_we_i = cpu_we;
  assign bus0.cpu_addr_i = cpu_addr;   assign bus1.cpu_addr_i = cpu_addr;
  assign bus0.cpu_wdata_i = cpu_wdata; assign bus1.cpu_wdata_i = cpu_wdata;
  assign bus0.dma_req_i = dma_req;  assign bus1.dma_req_i = dma_req;
  assign bus0.dma_we_i = dma_we;    assign bus1.dma_we_i = dma_we;
  assign bus0.dma_addr_i = dma_addr;   assign bus1.dma_addr_i = dma_addr;
  assign bus0.dma_wdata_i = dma_wdata; assign bus1.dma_wdata_i = dma_wdata;

  function automatic logic [31:0] pat(input int i);
    return (i == 1) ? 32'd5 : (32'hA500_0000 | 32'(i * 4));
  endfunction

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  assign bus0.mem_rdata_i = mem0[bus0.mem_addr_o[9:2]];
  assign bus1.mem_rdata_i = mem1[bus1.mem_addr_o[9:2]];

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) mem0[i] <= pat(i);
    else if (bus0.mem_en_o && bus0.mem_we_o) mem0[bus0.mem_addr_o[9:2]] <= bus0.mem_wdata_o;
  end
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) mem1[i] <= pat(i);
    else if (bus1.mem_en_o && bus1.mem_we_o) mem1[bus1.mem_addr_o[9:2]] <= bus1.mem_wdata_o;
  end

  logic        o_cpu_ack, o_dma_ack, o_cpu_stall, o_mem_en, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata, o_cpu_rdata, o_dma_rdata;
  assign o_cpu_ack   = sel ? bus1.cpu_ack_o   : bus0.cpu_ack_o;
  assign o_dma_ack   = sel ? bus1.dma_ack_o   : bus0.dma_ack_o;
  assign o_cpu_stall = sel ? bus1.cpu_stall_o : bus0.cpu_stall_o;
  assign o_mem_en    = sel ? bus1.mem_en_o    : bus0.mem_en_o;
  assign o_mem_we    = sel ? bus1.mem_we_o    : bus0.mem_we_o;
  assign o_mem_addr  = sel ? bus1.mem_addr_o  : bus0.mem_addr_o;
  assign o_mem_wdata = sel ? bus1.mem_wdata_o : bus0.mem_wdata_o;
  assign o_cpu_rdata = sel ? bus1.cpu_rdata_o : bus0.cpu_rdata_o;
  assign o_dma_rdata = sel ? bus1.dma_rdata_o : bus0.dma_rdata_o;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  logic [31:0] ref_mem [0:255];
  logic        p_we    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 0; dma_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
  endtask

  // One isolated access from an idle arbiter; chg moves the CPU address mid-access.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit chg, output logic [31:0] rd);
    int n, en_cnt, lat;
    bit bus_ok, stall_ok, other_ok, ack;
    lat = sel ? 1 : 2;
    if (!port) begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    else       begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
    #1;
    chk_b("stall_pre", o_cpu_stall, !port);
    n = 0; en_cnt = 0; bus_ok = 1; stall_ok = 1; other_ok = 1; ack = 0;
    while (!ack && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      ack = port ? o_dma_ack : o_cpu_ack;
      if (port ? o_cpu_ack : o_dma_ack) other_ok = 0;
      if (o_mem_en) begin
        en_cnt++;
        if (o_mem_addr !== addr || o_mem_we !== we || (we && o_mem_wdata !== wdata)) bus_ok = 0;
      end
      if (!port && !ack && o_cpu_stall !== 1'b1) stall_ok = 0;
      if (chg && n == 1) cpu_addr = addr ^ 32'h18;
    end
    chk("ack_latency", 32'(n), 32'(lat + 1));
    chk("busy_cycles", 32'(en_cnt), 32'(lat));
    chk_b("bus_stable", bus_ok, 1'b1);
    chk_b("other_ack", other_ok, 1'b1);
    if (!port) begin
      chk_b("stall_busy", stall_ok, 1'b1);
      chk_b("stall_ack", o_cpu_stall, 1'b0);
    end
    rd = port ? o_dma_rdata : o_cpu_rdata;
    if (we) ref_mem[addr[9:2]] = wdata;
    cpu_req = 0; dma_req = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req(input bit p);
    logic [31:0] a;
    a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    p_we[p] = 1'($urandom_range(0, 1));
    p_addr[p] = a;
    p_wdata[p] = $urandom;
    if (!p) begin cpu_req = 1; cpu_we = p_we[0]; cpu_addr = a; cpu_wdata = p_wdata[0]; end
    else    begin dma_req = 1; dma_we = p_we[1]; dma_addr = a; dma_wdata = p_wdata[1]; end
  endtask

  // Transaction-level model: arbiter free from next_free; a grant at edge e acks
  // after edge e+lat and frees the arbiter for edge e+lat+2. Must start after reset.
  task automatic traffic(input int n_cpu, input int n_dma, input bit rnd, output logic [3:0] ord);
    int rem [2];
    int e, next_free, exp_edge, last_ack, nack, lat;
    bit w, m_last, got [2];
    logic [31:0] exp_rd [2];
    lat = sel ? 1 : 2;
    rem[0] = n_cpu; rem[1] = n_dma;
    e = 0; next_free = 0; exp_edge = -1; last_ack = -1; nack = 0;
    m_last = 1'b1; w = 1'b0; ord = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    if (!rnd) begin
      if (rem[0] > 0) new_req(0);
      if (rem[1] > 0) new_req(1);
    end
    while ((rem[0] > 0 || rem[1] > 0) && e < 400) begin
      if (rnd) begin
        if (rem[0] > 0 && !cpu_req && $urandom_range(0, 1) == 1) new_req(0);
        if (rem[1] > 0 && !dma_req && $urandom_range(0, 1) == 1) new_req(1);
      end
      if (e >= next_free && (cpu_req || dma_req)) begin
        if (cpu_req && dma_req) w = (PRIO || m_last) ? 1'b0 : 1'b1;
        else w = dma_req;
        m_last = w; exp_edge = e + lat; next_free = e + lat + 2;
        if (p_we[w]) ref_mem[p_addr[w][9:2]] = p_wdata[w];
        else exp_rd[w] = ref_mem[p_addr[w][9:2]];
      end
      @(posedge clk);
      @(negedge clk);
      chk_b("cpu_ack", o_cpu_ack, (e == exp_edge) && !w);
      chk_b("dma_ack", o_dma_ack, (e == exp_edge) && w);
      got[0] = o_cpu_ack; got[1] = o_dma_ack;
      for (int p = 0; p < 2; p++) begin
        if (got[p] && rem[p] > 0) begin
          chk(p ? "dma_rdata" : "cpu_rdata", p ? o_dma_rdata : o_cpu_rdata, exp_rd[p]);
          if (nack < 4) ord[nack] = 1'(p);
          if (!rnd && last_ack >= 0) chk("ack_gap", 32'(e - last_ack), 32'(lat + 2));
          last_ack = e; nack++; rem[p]--;
          if (!rnd && rem[p] > 0) new_req(1'(p));
          else if (p == 0) cpu_req = 0;
          else dma_req = 0;
        end
      end
      e++;
    end
    chk("traffic_done", 32'(rem[0] + rem[1]), 32'd0);
    cpu_req = 0; dma_req = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        tbl [6];
    logic [31:0] rd;
    logic [3:0]  ord;
    bit          saw;

    // stores leave the port's rdata at its previous value
    tbl[0] = '{1'b0, 1'b0, 32'h04, 32'h0,         32'h5};
    tbl[1] = '{1'b1, 1'b1, 32'h1C, 32'hDEAD_BEEF, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h1C, 32'h0,         32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h1234_5678};
    tbl[5] = '{1'b1, 1'b0, 32'h0C, 32'h0,         32'hA500_000C};

    #2;
    do_reset();
    chk_b("rst_cpu_ack", o_cpu_ack, 1'b0);
    chk_b("rst_dma_ack", o_dma_ack, 1'b0);
    chk_b("rst_mem_en", o_mem_en, 1'b0);
    chk_b("rst_mem_we", o_mem_we, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk("rst_cpu_rdata", o_cpu_rdata, 32'h0);
    chk("rst_dma_rdata", o_dma_rdata, 32'h0);

    for (int i = 0; i < 6; i++) begin
      do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, rd);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    do_access(1'b0, 1'b0, 32'h08, 32'h0, 1'b1, rd);
    chk("addr_change_rdata", rd, 32'hA500_0008);

    // reset in the middle of a DMA store
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    chk_b("busy_en", o_mem_en, 1'b1);
    chk_b("busy_we", o_mem_we, 1'b1);
    rst = 1'b1;
    #1;
    chk_b("rst_async_en", o_mem_en, 1'b0);
    chk_b("rst_async_we", o_mem_we, 1'b0);
    dma_req = 0;
    saw = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (o_dma_ack) saw = 1;
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (o_dma_ack) saw = 1;
    end
    chk_b("no_abandoned_ack", saw, 1'b0);

    traffic(2, 2, 1'b0, ord);
    chk("grant_order", 32'(ord), PRIO ? 32'hC : 32'hA);

    sel = 1'b1;
    do_reset();
    traffic(10, 10, 1'b1, ord);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory between two requesters: the CPU MEM stage (load/store) and a DMA/loader port used for preloading inputs and dumping results.
- Serialises accesses with a req/ack handshake and a fixed-latency memory model.
- Drives a stall back to the pipeline while a CPU access is pending.
- Sits between the CPU MEM stage / DMA engine and the data memory.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory busy cycles per access; legal range 1 to 15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cpu_req_i  in  1  CPU access request; held until ack.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_W  CPU byte address.
- cpu_wdata_i  in  DATA_W  CPU store data.
- cpu_ack_o  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata_o  out  DATA_W  CPU load data; valid while cpu_ack_o=1 and held until the next CPU completion.
- cpu_stall_o  out  1  pipeline stall.
- dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i  in  1/1/ADDR_W/DATA_W  DMA request, same semantics as the CPU port.
- dma_ack_o  out  1  one-cycle completion pulse to the DMA port.
- dma_rdata_o  out  DATA_W  DMA load data; valid while dma_ack_o=1 and held until the next DMA completion.
- mem_en_o  out  1  memory enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; valid on the last BUSY cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all ack, mem_en_o and mem_we_o = 0.
  - rdata registers, latched address and latched write data = 0.
  - last_grant=DMA, so the CPU wins the first tie.
  - An access in flight is abandoned: no ack is issued and the memory strobes drop at once.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - If any req is 1 at the edge, pick a winner, latch its we/addr/wdata, load lat_cnt=MEM_LAT-1, and go to BUSY.
  - Arbitration (default): round-robin. When both request, grant the one not equal to last_grant. Update last_grant on every grant.
- BUSY:
  - mem_en_o=1; mem_we_o/mem_addr_o/mem_wdata_o come from the latched registers and are stable for the whole of BUSY.
  - lat_cnt decrements each cycle.
  - When lat_cnt==0: capture mem_rdata_i into the winner's rdata register (loads only; stores leave rdata unchanged), then go to DONE.
- DONE:
  - Winner's ack=1 for exactly one cycle; mem_en_o=0; go to IDLE unconditionally.
  - The requester must drop or renew req on the edge where it samples ack. A req still high in the IDLE cycle after DONE is treated as a new request.
- Latency: req sampled at edge N; ack high during cycle N+MEM_LAT+1.
  - Back-to-back accesses from one requester take MEM_LAT+2 cycles each.
- Request changes: changing addr/we/wdata while req is held has no effect after the grant, because values are latched at grant time.
- cpu_stall_o = cpu_req_i & ~cpu_ack_o (combinational). It is therefore 0 in the ack cycle, so the pipeline advances on that edge.
- The non-granted requester waits; its ack stays 0.
- Outside BUSY: mem_en_o=0 and mem_we_o=0. mem_addr_o and mem_wdata_o hold their last latched values.

Optional Feature:
- Macro DMEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. The CPU always wins a simultaneous request; last_grant is ignored and is still updated.
  - The DMA can starve while the CPU requests continuously; this is accepted.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package dmem_arb_pkg holds:
  - State encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Grant encoding: GNT_CPU=1'b0, GNT_DMA=1'b1.
  - Counter width constant LAT_W=4.
- Sub-module rr_pick2: combinational 2-way picker.
  - Inputs: two req bits, last_grant, and the priority mode selected by the macro.
  - Outputs: grant and valid.
- The FSM, latches and counters stay in dmem_arbiter.

Test Plan:
- CPU load only, MEM_LAT=2, mem word at 0x04 = 0x0000_0005, cpu_req at edge 0:
  - mem_en_o high for cycles 1–2 with addr 0x04.
  - cpu_ack_o=1 in cycle 3 with cpu_rdata_o=5.
  - cpu_stall_o=1 in cycles 0–2.
- DMA store of 0xDEAD_BEEF to 0x1C:
  - mem_we_o=1 for 2 cycles with addr 0x1C.
  - A later CPU load of 0x1C returns 0xDEAD_BEEF.
- CPU and DMA request together from reset:
  - Grant order is CPU, DMA, CPU, DMA, with acks spaced 4 cycles apart.
  - With DMEM_ARB_CPU_PRIO_EN defined, the CPU wins every time while it keeps requesting.
- Change cpu_addr_i from 0x08 to 0x10 during BUSY:
  - mem_addr_o stays 0x08 and the data is from 0x08.
- Assert rst_i in the middle of BUSY of a DMA store:
  - mem_en_o and mem_we_o go to 0 immediately.
  - No dma_ack_o is issued.
  - After release, the first simultaneous request grants the CPU.
- MEM_LAT=1 sweep with 20 random alternating requests:
  - Every ack arrives exactly 2 cycles after grant.
  - Each ack goes only to the granted port.
  - Never two acks in one cycle.
